// File: rtl/pipe_scoreboard_if.sv
// Issue/decode handshake between the ID stage and the register scoreboard.
// The master drives the issue and source fields; the slave returns the hazard decision and status.
interface pipe_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int PERF_W     = 16
);
  logic                  issue_valid_i;
  logic                  issue_we_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [LAT_W-1:0]      issue_lat_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  PCWrite_o;
  logic                  IF_ID_Write_o;
  logic                  issue_ok_o;
  logic [REG_ADDR_W:0]   busy_cnt_o;
  logic [PERF_W-1:0]     stall_cnt_o;

  modport master (
    output issue_valid_i, issue_we_i, issue_rd_i, issue_lat_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, flush_i,
    input  stall_o, PCWrite_o, IF_ID_Write_o, issue_ok_o, busy_cnt_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_we_i, issue_rd_i, issue_lat_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, flush_i,
    output stall_o, PCWrite_o, IF_ID_Write_o, issue_ok_o, busy_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register latency scoreboard: detects RAW/WAW hazards for the ID instruction,
// stalls issue until results are forwardable, and counts stalled cycles.
module pipe_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_scoreboard_if.slave     sb
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [LAT_W-1:0]      r_cnt [NUM_REGS];
  logic [PERF_W-1:0]     r_stall_cnt;

  logic [NUM_REGS-1:0]   w_busy;
  logic [REG_ADDR_W:0]   w_busy_cnt;
  logic                  w_raw;
  logic                  w_waw;
  logic                  w_stall;
  logic                  w_issue_ok;
  logic                  w_load;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_busy     = '0;
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy[i]  = (r_cnt[i] != '0);
      w_busy_cnt = w_busy_cnt + (REG_ADDR_W+1)'(w_busy[i]);
    end
  end

  // Hazards use pre-edge state, so an entry loaded this cycle is seen only from the next one.
  always_comb begin
    w_raw      = (sb.id_rs1_used_i && w_busy[sb.id_rs1_i]) ||
                 (sb.id_rs2_used_i && w_busy[sb.id_rs2_i]);
    w_waw      = sb.issue_we_i && (sb.issue_rd_i != '0) &&
                 (r_cnt[sb.issue_rd_i] > sb.issue_lat_i);
    w_stall    = !rst_i && sb.issue_valid_i && !sb.flush_i && (w_raw || w_waw);
    w_issue_ok = sb.issue_valid_i && !sb.flush_i && !w_stall;
    w_load     = w_issue_ok && sb.issue_we_i && (sb.issue_rd_i != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the counter array is a small register file that must be cleared on reset,
      // because stale entries would raise false hazards on the first issue.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          r_cnt[i] <= '0;
        end else if (w_load && (sb.issue_rd_i == REG_ADDR_W'(i))) begin
          r_cnt[i] <= sb.issue_lat_i;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign sb.stall_o       = w_stall;
  assign sb.PCWrite_o     = !w_stall;
  assign sb.IF_ID_Write_o = !w_stall;
  assign sb.issue_ok_o    = w_issue_ok;
  assign sb.busy_cnt_o    = w_busy_cnt;
  assign sb.stall_cnt_o   = r_stall_cnt;

endmodule
